freq_meter_eqp: RTL and testbench

Parametrised equal-precision (reciprocal) frequency meter. It counts whole periods of an external signal and reference clock cycles over a gate that opens and closes on signal edges. Software derives f_sig = CLK_HZ × sig_periods / ref_cycles with no ±1 signal-count error. It sits between the sig_in pin and the display/UART formatter. It adds input synchronisation, single-shot or continuous modes, overflow and no-signal reporting, and a result-valid strobe.

---
 rtl/freq_meter_eqp_pkg.sv | 22 ++
 rtl/freq_meter_eqp_if.sv | 33 +++
 rtl/freq_meter_eqp_sig_sync_edge.sv | 27 ++
 rtl/freq_meter_eqp.sv | 142 ++++++++++++++
 tb/tb_freq_meter_eqp.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_eqp_pkg.sv
// Shared types and default constants for the equal-precision frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    localparam int DEF_REF_W          = 32;
    localparam int DEF_SIG_W          = 32;
    localparam int DEF_GATE_CYCLES    = 50_000_000;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 100_000_000;

    typedef struct packed {
        logic ovf;
        logic no_sig;
    } status_t;

endpackage

// File: rtl/freq_meter_eqp_if.sv
// Control/result bundle of the frequency meter; the meter takes the slave side.
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int REF_W = DEF_REF_W,
    parameter int SIG_W = DEF_SIG_W
) ();

    // start is a level sampled only while idle (no ready); cont re-arms after
    // each result; result_valid is a one-cycle strobe with no back-pressure and
    // the result fields hold until the next strobe.
    logic             start;
    logic             cont;
    logic             busy;
    logic             gate_open;
    logic [SIG_W-1:0] sig_periods;
    logic [REF_W-1:0] ref_cycles;
    logic             result_valid;
    logic             ovf;
    logic             no_sig;
    state_t           state;

    modport master (
        output start, cont,
        input  busy, gate_open, sig_periods, ref_cycles, result_valid, ovf, no_sig, state
    );

    modport slave (
        input  start, cont,
        output busy, gate_open, sig_periods, ref_cycles, result_valid, ovf, no_sig, state
    );

endinterface

// File: rtl/freq_meter_eqp_sig_sync_edge.sv
// Synchroniser for the asynchronous sig_in pin plus a registered rising-edge pulse.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Pin edge to pulse is SYNC_STAGES+1 cycles; the pulse itself is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            edge_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/freq_meter_eqp.sv
// Reciprocal frequency meter: FSM, period/reference/gate counters and result registers.
// Optional no-signal timeout in ARM/CLOSE is built when FREQ_METER_TIMEOUT_EN is defined.
module freq_meter_eqp
    import freq_meter_pkg::*;
#(
    parameter int REF_W          = DEF_REF_W,
    parameter int SIG_W          = DEF_SIG_W,
    parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic          clk,
    input logic          rst,
    input logic          sig_in,
    freq_meter_if.slave  bus
);

    localparam logic [REF_W-1:0] REF_MAX   = {REF_W{1'b1}};
    localparam logic [SIG_W-1:0] SIG_MAX   = {SIG_W{1'b1}};
    localparam logic [REF_W-1:0] GATE_LAST = REF_W'(GATE_CYCLES);

    state_t           state;
    logic             edge_pulse;
    logic [SIG_W-1:0] sig_cnt, sig_res, sig_inc;
    logic [REF_W-1:0] ref_cnt, ref_res, ref_inc;
    logic [REF_W-1:0] gate_cnt, gate_next;
    logic             sat_q, sat_now;
    logic             gate_q, valid_q;
    logic             gate_done, close_now, to_fire;
    status_t          status_q;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .edge_pulse(edge_pulse)
    );

    // Both counters stick at all-ones; any attempt to step past it marks saturation.
    always_comb begin
        sig_inc = sig_cnt;
        if (edge_pulse && (sig_cnt != SIG_MAX)) begin
            sig_inc = sig_cnt + 1'b1;
        end
        ref_inc   = (ref_cnt == REF_MAX) ? ref_cnt : ref_cnt + 1'b1;
        gate_next = gate_cnt + 1'b1;
        gate_done = (gate_next == GATE_LAST);
        sat_now   = sat_q | (ref_cnt == REF_MAX) | (edge_pulse & (sig_cnt == SIG_MAX));
        close_now = edge_pulse && ((state == CLOSE) || ((state == GATE) && gate_done));
    end

`ifdef FREQ_METER_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting = (state == ARM) || (state == CLOSE);
    assign to_fire = waiting && !edge_pulse && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!waiting || edge_pulse || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sig_cnt  <= '0;
            ref_cnt  <= '0;
            gate_cnt <= '0;
            sat_q    <= 1'b0;
            gate_q   <= 1'b0;
            valid_q  <= 1'b0;
            sig_res  <= '0;
            ref_res  <= '0;
            status_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start || bus.cont) state <= ARM;
                end
                ARM: begin
                    if (edge_pulse) begin
                        sig_cnt  <= '0;
                        ref_cnt  <= '0;
                        gate_cnt <= '0;
                        sat_q    <= 1'b0;
                        gate_q   <= 1'b1;
                        state    <= GATE;
                    end
                end
                GATE: begin
                    ref_cnt  <= ref_inc;
                    gate_cnt <= gate_next;
                    sig_cnt  <= sig_inc;
                    sat_q    <= sat_now;
                    if (gate_done) state <= CLOSE;
                end
                CLOSE: begin
                    ref_cnt <= ref_inc;
                    sig_cnt <= sig_inc;
                    sat_q   <= sat_now;
                end
                default: state <= IDLE;
            endcase

            // A closing edge on the last gate cycle overrides the move into CLOSE.
            if (close_now || to_fire) begin
                valid_q         <= 1'b1;
                gate_q          <= 1'b0;
                state           <= bus.cont ? ARM : IDLE;
                sig_res         <= close_now ? sig_inc : '0;
                ref_res         <= close_now ? ref_inc : '0;
                status_q.ovf    <= close_now & sat_now;
                status_q.no_sig <= !close_now;
            end
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.gate_open    = gate_q;
    assign bus.sig_periods  = sig_res;
    assign bus.ref_cycles   = ref_res;
    assign bus.result_valid = valid_q;
    assign bus.ovf          = status_q.ovf;
    assign bus.no_sig       = status_q.no_sig;
    assign bus.state        = state;

endmodule

// File: tb/tb_freq_meter_eqp.sv
// Bench for freq_meter_eqp: a wide and a 10-bit-reference instance see the same sig_in.
module tb_freq_meter_eqp;
    import freq_meter_pkg::*;

    localparam int GATE    = 1000;
    localparam int TOUT    = 5000;
    localparam int SMALL_W = 10;

    typedef struct packed {
        logic [31:0] sig;
        logic [31:0] refc;
        logic        ovf;
        logic        no_sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig_in = 1'b0;
    logic cont_pos = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   sig_period = 0;
    int   sig_high = 0;
    bit   abort_gate = 1'b0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   gate_q[$];

    freq_meter_if #(.REF_W(32),      .SIG_W(32)) bus_a ();
    freq_meter_if #(.REF_W(SMALL_W), .SIG_W(32)) bus_b ();

    freq_meter_eqp #(
        .REF_W(32), .SIG_W(32), .GATE_CYCLES(GATE), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TOUT)
    ) u_dut (.clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_a));

    freq_meter_eqp #(
        .REF_W(SMALL_W), .SIG_W(32), .GATE_CYCLES(GATE), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TOUT)
    ) u_small (.clk(clk), .rst(rst), .sig_in(sig_in), .bus(bus_b));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cont_pos <= bus_a.cont;

    initial begin
        #900_000;
        $display("FAIL watchdog: got no end of test, want end within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Steady square wave of sig_period cycles (high for sig_high); period 0 holds low.
    initial begin
        int p;
        int h;
        forever begin
            p = sig_period;
            h = sig_high;
            if (p == 0) begin
                sig_in = 1'b0;
                @(negedge clk);
            end else begin
                sig_in = 1'b1;
                repeat (h) @(negedge clk);
                sig_in = 1'b0;
                repeat (p - h) @(negedge clk);
            end
        end
    end

    // ---------------- reference model ----------------
    // A measurement spans the fewest whole periods covering the gate; each
    // counter then clips at its all-ones value.
    function automatic exp_t model(int p, int ref_w);
        exp_t   e;
        longint n, r, rmax;
        n        = (GATE + p - 1) / p;
        r        = n * p;
        rmax     = (longint'(1) << ref_w) - 1;
        e.sig    = 32'(n);
        e.refc   = (r > rmax) ? 32'(rmax) : 32'(r);
        e.ovf    = (r > rmax);
        e.no_sig = 1'b0;
        return e;
    endfunction

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endfunction

    function automatic void check_res(string name, exp_t got, exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got sig=%0d ref=%0d ovf=%0b no_sig=%0b want sig=%0d ref=%0d ovf=%0b no_sig=%0b",
                     name, got.sig, got.refc, got.ovf, got.no_sig,
                     want.sig, want.refc, want.ovf, want.no_sig);
        end
    endfunction

    function automatic void unexpected(string name, int got);
        total++;
        bad++;
        $display("FAIL %s: got event with value %0d want no event", name, got);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int     gate_len;
        bit     chk_pending;
        state_t chk_state;
        exp_t   got;
        gate_len    = 0;
        chk_pending = 1'b0;
        chk_state   = IDLE;
        forever begin
            @(negedge clk);
            if (chk_pending) begin
                check("state_after_result", 64'(bus_a.state), 64'(chk_state));
                chk_pending = 1'b0;
            end
            if (bus_a.result_valid) begin
                got = {bus_a.sig_periods, bus_a.ref_cycles, bus_a.ovf, bus_a.no_sig};
                if (exp_a.size() == 0) unexpected("result_a", int'(got.sig));
                else check_res("result_a", got, exp_a.pop_front());
                chk_pending = 1'b1;
                chk_state   = cont_pos ? ARM : IDLE;
            end
            if (bus_b.result_valid) begin
                got = {bus_b.sig_periods, 32'(bus_b.ref_cycles), bus_b.ovf, bus_b.no_sig};
                if (exp_b.size() == 0) unexpected("result_b", int'(got.sig));
                else check_res("result_b", got, exp_b.pop_front());
            end
            if (bus_a.gate_open) begin
                gate_len++;
            end else if (gate_len > 0) begin
                if (abort_gate) abort_gate = 1'b0;
                else if (gate_q.size() == 0) unexpected("gate_len", gate_len);
                else check("gate_len", 64'(gate_len), 64'(gate_q.pop_front()));
                gate_len = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_sig(int p, int h);
        sig_period = p;
        sig_high   = h;
    endtask

    task automatic set_cont(logic v);
        bus_a.cont = v;
        bus_b.cont = v;
    endtask

    task automatic pulse_start();
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check("busy_after_start", 64'(bus_a.busy), 64'd1);
    endtask

    task automatic push_exp(int p);
        exp_t ea;
        ea = model(p, 32);
        exp_a.push_back(ea);
        exp_b.push_back(model(p, SMALL_W));
        gate_q.push_back(int'(ea.refc));
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || bus_a.busy || bus_b.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_done: got %0d results still pending after %0d cycles want 0",
                     exp_a.size(), budget);
            exp_a.delete();
            exp_b.delete();
            gate_q.delete();
        end
    endtask

    task automatic measure(int p, int h);
        set_sig(p, h);
        repeat (3 * p + 10) @(negedge clk);
        push_exp(p);
        pulse_start();
        wait_done(3 * GATE + 3 * p + 200);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_busy"},   64'(bus_a.busy),         64'd0);
        check({tag, "_gate"},   64'(bus_a.gate_open),    64'd0);
        check({tag, "_sig"},    64'(bus_a.sig_periods),  64'd0);
        check({tag, "_ref"},    64'(bus_a.ref_cycles),   64'd0);
        check({tag, "_valid"},  64'(bus_a.result_valid), 64'd0);
        check({tag, "_ovf"},    64'(bus_a.ovf),          64'd0);
        check({tag, "_no_sig"}, 64'(bus_a.no_sig),       64'd0);
        check({tag, "_state"},  64'(bus_a.state),        64'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        set_cont(1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        measure(20, 10);     // coincident close: 50 / 1000
        measure(30, 12);     // close after gate: 34 / 1020
        measure(1500, 700);  // saturates the 10-bit reference count

        // Continuous mode: three back-to-back results, then cont drops during the fourth.
        set_sig(30, 15);
        repeat (100) @(negedge clk);
        for (int i = 0; i < 4; i++) push_exp(30);
        set_cont(1'b1);
        n = 0;
        while (exp_a.size() > 1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        set_cont(1'b0);
        wait_done(3000);

        // A period that lands the count exactly on 1023 is avoided: whether an
        // all-ones value reached without overshoot is saturation is left open.
        for (int i = 0; i < 8; i++) begin
            int p;
            int h;
            do p = $urandom_range(8, 150); while (((GATE + p - 1) / p) * p == 1023);
            h = $urandom_range(2, p - 3);
            measure(p, h);
        end

        // Reset in the middle of a gate aborts the measurement silently.
        set_sig(40, 20);
        repeat (130) @(negedge clk);
        pulse_start();
        n = 0;
        while (!bus_a.gate_open && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) unexpected("gate_never_opened", n);
        repeat (200) @(negedge clk);
        abort_gate = 1'b1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2500) @(negedge clk);
        measure(40, 20);

`ifdef FREQ_METER_TIMEOUT_EN
        set_sig(0, 0);
        repeat (50) @(negedge clk);
        exp_a.push_back('{sig: 32'd0, refc: 32'd0, ovf: 1'b0, no_sig: 1'b1});
        exp_b.push_back('{sig: 32'd0, refc: 32'd0, ovf: 1'b0, no_sig: 1'b1});
        pulse_start();
        n = 1;
        while (exp_a.size() != 0 && n < TOUT + 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < TOUT - 5 || n > TOUT + 5) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles want about %0d", n, TOUT);
        end
        wait_done(200);
`endif

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
